slow_clk_tick_recover: RTL and testbench
========================================

// Module: slow_clk_tick_recover
// PURPOSE
//  Consumer end of the clock-divider path: samples a divided clock (slow_clk) as data in the
//  fast clk domain, synchronises it, and turns its edges into single-cycle enable pulses.
//  Measures the slow period, flags a stalled divider, and prescales edges into a game tick
//  (gravity/drop step), so that game logic runs on clk with enables and never on a derived clock.
// PARAMETERS
//  SYNC_STAGES  2   flops in the slow_clk synchroniser (>=2)
//  PERIOD_W     8   width of the period counter/output
//  TIMEOUT      64  clk cycles without a rising edge before lost asserts (< 2**PERIOD_W)
//  DIV_W        4   width of tick_div
// PORTS
//  clk           in   1         system clock; all logic on posedge
//  rst           in   1         async, active-high reset
//  slow_clk      in   1         divided clock, treated as asynchronous data
//  enable        in   1         1 = run; 0 = hold tick prescaler, suppress tick_out
//  tick_div      in   DIV_W     tick_out fires every tick_div+1 rising edges
//  rise_pulse    out  1         1-cycle pulse per synchronised rising edge
//  fall_pulse    out  1         1-cycle pulse per synchronised falling edge
//  tick_out      out  1         1-cycle prescaled game tick
//  period        out  PERIOD_W  clk cycles between the last two rising edges
//  period_valid  out  1         period holds a real measurement
//  lost          out  1         no rising edge for TIMEOUT cycles
// BEHAVIOUR
//  - Reset: all outputs 0, sync chain 0, counters 0, FSM = ACQUIRE. Reset mid-operation
//    discards any measurement; ACQUIRE resumes on the first clk edge after rst falls.
//  - Sync: SYNC_STAGES-flop chain, then one history flop. rise_pulse = sync & ~hist, fall_pulse
//    = ~sync & hist, both registered: a level change on slow_clk sampled at clk edge N gives the
//    pulse high during the cycle after edge N+SYNC_STAGES (fixed latency SYNC_STAGES+1 cycles).
//  - Period counter pcnt: cleared to 1 on each rise_pulse event, else increments, saturates at
//    all-ones (no wrap). On a rise in MEASURE/LOCKED, period <= pcnt (cycle count since previous rise).
//  - FSM (advances on the internal rise event, same cycle rise_pulse is registered):
//    ACQUIRE: rise -> MEASURE (period not updated, period_valid stays 0).
//    MEASURE: rise -> LOCKED, period updated, period_valid <= 1.
//    LOCKED:  rise -> LOCKED, period updated. pcnt reaches TIMEOUT -> LOST.
//    MEASURE: pcnt reaches TIMEOUT -> LOST.
//    LOST:    lost=1, period_valid=0, period holds last value; rise -> MEASURE, lost <= 0.
//    ACQUIRE never times out (lost stays 0 until one edge has been seen).
//  - lost is a registered decode of state==LOST.
//  - Tick prescaler tcnt (DIV_W bits): on rise while enable=1 and state in MEASURE/LOCKED:
//    if tcnt >= tick_div then tcnt<=0 and tick_out pulses (same cycle as rise_pulse) else tcnt++.
//    tick_div=0 -> tick every rise. tick_div lowered below tcnt -> next rise fires and clears.
//    enable=0: tcnt held, tick_out=0; rise/fall_pulse, period and FSM keep running.
//    Entering LOST clears tcnt. No tick in ACQUIRE.
//  - Glitch-free: a slow_clk pulse shorter than one clk period may be missed; no other
//    guarantee. Simultaneous rise and timeout in one cycle: rise wins.
// STRUCTURE
//  - Shared package: FSM state enum (ACQUIRE, MEASURE, LOCKED, LOST), 2-bit encoding.
//  - One sub-module: sync_edge_detect (SYNC_STAGES param; ports clk, rst, d_async,
//    level, rise, fall), reusable for button/keypad inputs. Period, FSM, prescaler stay here.
// TESTING
//  1 slow_clk toggled every 2 clk (negedge-aligned, as the divider produces), tick_div=0 ->
//    first rise_pulse 3 cycles after first high sample; period=4, period_valid after 2nd rise;
//    tick_out every 4 cycles.
//  2 tick_div=2, enable=1, period 4 -> tick_out on every 3rd rise (every 12 cycles);
//    drop enable for 2 rises -> no ticks, tcnt held, resumes count where it left.
//  3 Hold slow_clk low after lock -> lost=1 exactly TIMEOUT=64 cycles after the last rise,
//    period_valid=0, period holds 4; restart toggling -> lost clears on first rise, valid on 2nd.
//  4 Stretch one slow period to 300 cycles with TIMEOUT raised to 255 -> pcnt saturates at 255,
//    lost at 255; no wrap-induced false period.
//  5 Assert rst for 1 cycle mid-LOCKED -> all outputs 0 asynchronously; ACQUIRE, no tick until
//    second recovered rise.
//  6 Random-phase slow_clk vs clk (≥1000 edges) -> count of rise_pulse equals count of
//    slow_clk rising edges, every pulse exactly 1 cycle wide.

Source files
------------

// File: rtl/slow_clk_tick_recover_pkg.sv
// Shared types for the slow-clock recovery block.
// Holds the lock-tracking FSM encoding and the helper that says when ticks and periods are live.
package slow_clk_tick_recover_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    // Period capture and tick prescaling are only meaningful once a previous rise exists.
    function automatic logic is_running(input state_t s);
        return (s == ST_MEASURE) || (s == ST_LOCKED);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level, followed by a history flop for edge detection.
// Reusable for buttons and keypad lines; rise/fall are decoded from flops only, so they are glitch-free.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's pre-edge value.
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/slow_clk_tick_recover.sv
// Turns a divided clock, sampled as data, into clk-domain enable pulses, a period measurement,
// a stall flag and a prescaled game tick, so game logic never runs on a derived clock.
module slow_clk_tick_recover
    import slow_clk_tick_recover_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_W    = 8,
    parameter int TIMEOUT     = 64,
    parameter int DIV_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                slow_clk,
    input  logic                enable,
    input  logic [DIV_W-1:0]    tick_div,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic                tick_out,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                lost
);

    localparam logic [PERIOD_W-1:0] PCNT_MAX    = '1;
    localparam logic [PERIOD_W-1:0] TIMEOUT_CNT = PERIOD_W'(TIMEOUT);

    logic                rise_evt;
    logic                fall_evt;
    logic                unused_level;
    logic                running;
    logic                timed_out;
    logic [PERIOD_W-1:0] pcnt;
    logic [PERIOD_W-1:0] period_d;
    logic [DIV_W-1:0]    tcnt;
    logic [DIV_W-1:0]    tcnt_d;
    logic                tick_d;
    state_t              state_q;
    state_t              state_d;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_async(slow_clk),
        .level  (unused_level),
        .rise   (rise_evt),
        .fall   (fall_evt)
    );

    assign running   = is_running(state_q);
    assign timed_out = (pcnt >= TIMEOUT_CNT);

    // Restarting at 1 makes pcnt read the rise-to-rise distance at the next rise; it saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (rise_evt) begin
            pcnt <= PERIOD_W'(1);
        end else if (pcnt != PCNT_MAX) begin
            pcnt <= pcnt + PERIOD_W'(1);
        end
    end

    always_comb begin
        // NOTE: defaults first, so no branch leaves a variable unassigned and infers a latch.
        state_d  = state_q;
        period_d = period;
        tcnt_d   = tcnt;
        tick_d   = 1'b0;

        // A rise in the same cycle as a timeout keeps the block alive.
        if (rise_evt) begin
            case (state_q)
                ST_ACQUIRE: state_d = ST_MEASURE;
                ST_MEASURE: state_d = ST_LOCKED;
                ST_LOCKED:  state_d = ST_LOCKED;
                ST_LOST:    state_d = ST_MEASURE;
                default:    state_d = ST_ACQUIRE;
            endcase
        end else if (timed_out && running) begin
            state_d = ST_LOST;
        end

        if (rise_evt && running) begin
            period_d = pcnt;
        end

        if (state_d == ST_LOST) begin
            tcnt_d = '0;
        end else if (rise_evt && running && enable) begin
            if (tcnt >= tick_div) begin
                tcnt_d = '0;
                tick_d = 1'b1;
            end else begin
                tcnt_d = tcnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ACQUIRE;
            tcnt         <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            lost         <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            tick_out     <= 1'b0;
        end else begin
            state_q      <= state_d;
            tcnt         <= tcnt_d;
            period       <= period_d;
            period_valid <= (state_d == ST_LOCKED);
            lost         <= (state_d == ST_LOST);
            rise_pulse   <= rise_evt;
            fall_pulse   <= fall_evt;
            tick_out     <= tick_d;
        end
    end

endmodule

// File: tb/tb_slow_clk_tick_recover.sv
// Self-checking bench: edge scoreboard keyed on clk samples of slow_clk, a table of rise bursts
// with expected ticks/period/flags, and hand sequences for timeout, saturation, reset, random phase.
module tb_slow_clk_tick_recover;

    localparam int SYNC_STAGES = 2;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       slow_clk = 1'b0;
    logic       enable   = 1'b1;
    logic [3:0] tick_div = 4'd0;

    logic       rise_pulse, fall_pulse, tick_out, period_valid, lost;
    logic [7:0] period;
    logic       l_rise, l_fall, l_tick, l_valid, l_lost;
    logic [7:0] l_period;

    slow_clk_tick_recover #(
        .SYNC_STAGES(SYNC_STAGES), .PERIOD_W(8), .TIMEOUT(64), .DIV_W(4)
    ) dut (
        .clk(clk), .rst(rst), .slow_clk(slow_clk), .enable(enable), .tick_div(tick_div),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .tick_out(tick_out),
        .period(period), .period_valid(period_valid), .lost(lost)
    );

    slow_clk_tick_recover #(
        .SYNC_STAGES(SYNC_STAGES), .PERIOD_W(8), .TIMEOUT(255), .DIV_W(4)
    ) dut_long (
        .clk(clk), .rst(rst), .slow_clk(slow_clk), .enable(enable), .tick_div(tick_div),
        .rise_pulse(l_rise), .fall_pulse(l_fall), .tick_out(l_tick),
        .period(l_period), .period_valid(l_valid), .lost(l_lost)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: a level change seen at clk edge N must show as a pulse after edge N+SYNC_STAGES.
    typedef struct {
        int   cyc;
        logic lvl;
    } sb_t;

    sb_t  sb_q[$];
    int   cyc    = 0;
    logic prev_s = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            sb_q.delete();
            prev_s <= 1'b0;
        end else begin
            if (slow_clk !== prev_s) sb_q.push_back('{cyc + 1 + SYNC_STAGES, slow_clk});
            prev_s <= slow_clk;
        end
        cyc <= cyc + 1;
    end

    int n_ticks       = 0;
    int last_tick     = -1;
    int last_gap      = 0;
    int last_exp_rise = 0;
    bit count_en      = 1'b0;
    int n_src_rise    = 0;
    int n_dut_rise    = 0;

    always @(posedge slow_clk) if (count_en) n_src_rise++;

    always @(negedge clk) begin : monitor
        logic exp_r;
        logic exp_f;
        if (!rst) begin
            while (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
                check("edge_pulse_missed", 32'd0, 32'd1);
                void'(sb_q.pop_front());
            end
            exp_r = 1'b0;
            exp_f = 1'b0;
            if (sb_q.size() != 0 && sb_q[0].cyc == cyc) begin
                if (sb_q[0].lvl) exp_r = 1'b1;
                else exp_f = 1'b1;
                void'(sb_q.pop_front());
            end
            if (exp_r || rise_pulse) check("rise_pulse", rise_pulse, exp_r);
            if (exp_f || fall_pulse) check("fall_pulse", fall_pulse, exp_f);
            if (exp_r) last_exp_rise = cyc;
            if (rise_pulse && count_en) n_dut_rise++;
            if (tick_out) begin
                check("tick_with_rise", rise_pulse, 1'b1);
                n_ticks++;
                if (last_tick >= 0) last_gap = cyc - last_tick;
                last_tick = cyc;
            end
        end
    end

    typedef struct {
        int         n;
        int         half;
        logic       en;
        logic [3:0] div;
        int         exp_ticks;
        int         exp_gap;
        logic [7:0] exp_period;
        logic       exp_valid;
        logic       exp_lost;
    } vec_t;

    vec_t tbl[19];

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            enable    = tbl[i].en;
            tick_div  = tbl[i].div;
            n_ticks   = 0;
            last_tick = -1;
            last_gap  = 0;
            for (int r = 0; r < tbl[i].n; r++) begin
                slow_clk = 1'b1;
                repeat (tbl[i].half) @(negedge clk);
                slow_clk = 1'b0;
                repeat (tbl[i].half) @(negedge clk);
            end
            check($sformatf("row%0d_ticks", i), n_ticks, tbl[i].exp_ticks);
            if (tbl[i].exp_gap != 0) check($sformatf("row%0d_gap", i), last_gap, tbl[i].exp_gap);
            check($sformatf("row%0d_period", i), period, tbl[i].exp_period);
            check($sformatf("row%0d_valid", i), period_valid, tbl[i].exp_valid);
            check($sformatf("row%0d_lost", i), lost, tbl[i].exp_lost);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rise"}, rise_pulse, 0);
        check({tag, "_fall"}, fall_pulse, 0);
        check({tag, "_tick"}, tick_out, 0);
        check({tag, "_period"}, period, 0);
        check({tag, "_valid"}, period_valid, 0);
        check({tag, "_lost"}, lost, 0);
        check({tag, "_l_rise"}, l_rise, 0);
        check({tag, "_l_fall"}, l_fall, 0);
        check({tag, "_l_tick"}, l_tick, 0);
        check({tag, "_l_period"}, l_period, 0);
        check({tag, "_l_valid"}, l_valid, 0);
        check({tag, "_l_lost"}, l_lost, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        //            n half en    div   ticks gap per  valid lost
        tbl[0]  = '{1, 2, 1'b1, 4'd0, 0, 0,  8'd0, 1'b0, 1'b0};
        tbl[1]  = '{1, 2, 1'b1, 4'd0, 1, 0,  8'd4, 1'b1, 1'b0};
        tbl[2]  = '{4, 2, 1'b1, 4'd0, 4, 4,  8'd4, 1'b1, 1'b0};
        tbl[3]  = '{6, 2, 1'b1, 4'd2, 2, 12, 8'd4, 1'b1, 1'b0};
        tbl[4]  = '{1, 2, 1'b1, 4'd2, 0, 0,  8'd4, 1'b1, 1'b0};
        tbl[5]  = '{2, 2, 1'b0, 4'd2, 0, 0,  8'd4, 1'b1, 1'b0};
        tbl[6]  = '{1, 2, 1'b1, 4'd2, 0, 0,  8'd4, 1'b1, 1'b0};
        tbl[7]  = '{1, 2, 1'b1, 4'd2, 1, 0,  8'd4, 1'b1, 1'b0};
        tbl[8]  = '{2, 2, 1'b1, 4'd3, 0, 0,  8'd4, 1'b1, 1'b0};
        tbl[9]  = '{1, 2, 1'b1, 4'd1, 1, 0,  8'd4, 1'b1, 1'b0};
        tbl[10] = '{2, 3, 1'b1, 4'd0, 2, 6,  8'd6, 1'b1, 1'b0};
        tbl[11] = '{2, 2, 1'b1, 4'd2, 0, 0,  8'd4, 1'b1, 1'b0};
        tbl[12] = '{1, 2, 1'b1, 4'd1, 0, 0,  8'd4, 1'b0, 1'b0};
        tbl[13] = '{1, 2, 1'b1, 4'd1, 0, 0,  8'd4, 1'b1, 1'b0};
        tbl[14] = '{1, 2, 1'b1, 4'd1, 1, 0,  8'd4, 1'b1, 1'b0};
        tbl[15] = '{1, 2, 1'b1, 4'd0, 0, 0,  8'd4, 1'b0, 1'b0};
        tbl[16] = '{1, 2, 1'b1, 4'd0, 1, 0,  8'd4, 1'b1, 1'b0};
        tbl[17] = '{1, 2, 1'b1, 4'd0, 0, 0,  8'd0, 1'b0, 1'b0};
        tbl[18] = '{1, 2, 1'b1, 4'd0, 1, 0,  8'd4, 1'b1, 1'b0};

        @(negedge clk);
        check_all_zero("reset");
        #2 rst = 1'b0;
        @(negedge clk);

        // Lock, prescale, enable hold, lowered divider, period change.
        apply_rows(0, 11);

        // Stall after lock: lost exactly 64 cycles after the last rise, period kept.
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (lost) break;
        end
        check("lost_delay", cyc - last_exp_rise, 64);
        check("lost_valid", period_valid, 0);
        check("lost_period", period, 4);
        check("long_not_lost", l_lost, 0);
        check("long_valid", l_valid, 1);

        // Recovery: lost clears on the first rise, valid on the second, tcnt restarted from 0.
        apply_rows(12, 14);

        // 300-cycle period against the 255 timeout: saturate, no wrap, period untouched.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (l_lost) break;
        end
        check("long_lost_delay", cyc - last_exp_rise, 255);
        check("long_lost_valid", l_valid, 0);
        check("short_lost_too", lost, 1);
        repeat (40) @(negedge clk);
        check("long_lost_held", l_lost, 1);
        check("long_period_held", l_period, 4);
        apply_rows(15, 15);
        check("long_lost_cleared", l_lost, 0);
        check("long_period_after", l_period, 4);
        check("long_valid_after", l_valid, 0);
        apply_rows(16, 16);

        // One-cycle reset while locked: outputs clear immediately, full reacquire needed.
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        apply_rows(17, 18);

        // Random phase: every source rising edge yields exactly one 1-cycle rise_pulse.
        count_en = 1'b1;
        for (int e = 0; e < 2200; e++) begin
            int d;
            d = $urandom_range(12, 31);
            #d;
            if (($time % 10) == 5) #1;
            slow_clk = ~slow_clk;
        end
        @(negedge clk);
        slow_clk = 1'b0;
        repeat (8) @(negedge clk);
        count_en = 1'b0;
        check("random_rise_count", n_dut_rise, n_src_rise);
        check("random_enough_edges", (n_src_rise >= 1000) ? 1 : 0, 1);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
